ras_stack: RTL

- Return-address stack storage and speculation-recovery block behind the fetch-side RAS interface.
- Consumes fetch's push/pop/new_addr/branch_fetched requests and the branch predictor's branch_retired.
- Produces the predicted return address (addr) for fetch.
- Holds a circular LUT stack plus a checkpoint FIFO of stack pointers, so the pointer can be restored after a branch flush.

---
 rtl/ras_stack.sv | 118 +++++++++++
 1 files changed

// File: rtl/ras_stack.sv
// Return-address stack with a checkpoint FIFO of stack pointers for flush recovery.
// One-cycle request-to-addr latency; no backpressure beyond ckpt_full, which tells fetch to stop checkpointing.

// Generic FIFO with a synchronous flush. rd_dat is the head entry and count tracks the live entries.
// A write and a read in the same cycle are accepted even when the FIFO is full. Writes made while full without a read are dropped.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_vld,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic                     rd_rdy,
  output logic [WIDTH-1:0]         rd_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    head, tail;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en, rd_en;

  assign full   = (count == CW'(DEPTH));
  assign rd_en  = rd_rdy && !flush && (count != '0);
  assign wr_en  = wr_vld && !flush && (!full || rd_en);
  assign rd_dat = mem[head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_en) tail <= tail + AW'(1);
      if (rd_en) head <= head + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: it is only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (wr_en) mem[tail] <= wr_dat;
  end
endmodule

module ras_stack #(
  parameter int RAS_DEPTH  = 8,
  parameter int CKPT_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic [31:0]                   new_addr,
  input  logic                          branch_fetched,
  input  logic                          branch_retired,
  input  logic                          recover,
  output logic [31:0]                   addr,
  output logic                          ckpt_full,
  output logic [$clog2(CKPT_DEPTH):0]   ckpt_count
);
  localparam int RI_W = $clog2(RAS_DEPTH);

  logic [RI_W-1:0] ri, ri_inc, ri_dec, ckpt_head;
  logic [31:0]     stack [RAS_DEPTH];

  assign ri_inc = ri + RI_W'(1);
  assign ri_dec = ri - RI_W'(1);
  assign addr   = stack[ri];

  // The checkpoint captures ri before this cycle's push/pop, so it feeds from the register.
  fifo #(
    .WIDTH (RI_W),
    .DEPTH (CKPT_DEPTH)
  ) u_ckpt_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (recover),
    .wr_vld (branch_fetched),
    .wr_dat (ri),
    .rd_rdy (branch_retired),
    .rd_dat (ckpt_head),
    .count  (ckpt_count),
    .full   (ckpt_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ri <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) stack[i] <= '0;
    end else if (recover) begin
      // Only the pointer is rolled back; entries written on the wrong path stay.
      if (ckpt_count != '0) ri <= ckpt_head;
    end else begin
      case ({push, pop})
        2'b10: begin
          ri            <= ri_inc;
          stack[ri_inc] <= new_addr;
        end
        2'b01:   ri <= ri_dec;
        2'b11:   stack[ri] <= new_addr;
        default: ri <= ri;
      endcase
    end
  end
endmodule
